// File: rtl/n64a_vmux_pkg.sv
// Shared video-bus definitions for the N64 VD mux/demux path.
// Latency: n/a (types, constants and a pure formatting function).
// Backpressure: n/a.
package n64a_vmux_pkg;

   localparam int COLOR_W = 7;
   localparam int VDATA_W = 4 + 3 * COLOR_W;

   // Bus phase currently driven on VD; the demux side shares this encoding.
   typedef enum logic [1:0] {
      PH_SYNC = 2'd0,
      PH_R    = 2'd1,
      PH_G    = 2'd2,
      PH_B    = 2'd3
   } vphase_t;

   // Parallel pixel as carried on pix_i: {B,G,R,sync}.
   // sync bits: [3] nVSYNC, [2] nCLAMP, [1] nHSYNC, [0] nCSYNC.
   typedef struct packed {
      logic [COLOR_W-1:0] b;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] r;
      logic [3:0]         sync;
   } vpix_t;

   // modeparams bit positions
   localparam int MODE_LOWRES_REP = 2;
   localparam int MODE_BLANK_REP  = 1;
   localparam int MODE_N15BIT     = 0;

   // In 15-bit mode only the upper five bits of each channel are meaningful.
   function automatic logic [COLOR_W-1:0] fmt_color(input logic [COLOR_W-1:0] c,
                                                    input logic               n15bit);
      return n15bit ? c : {c[COLOR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/n64a_vmux.sv
// Serialises parallel pixels into the 4-phase N64 VD stream (sync, R, G, B), optional blanked repeat.
// Latency: accept at edge T -> sync on bus at T+1, R T+2, G T+3, B T+4.
// Backpressure: pix_ready_o only at a non-repeat pixel boundary; a missing pixel there repeats the last one and pulses underrun_o.
module n64a_vmux
   import n64a_vmux_pkg::*;
(
   input  logic               VCLK,
   input  logic               nRST,
   input  logic [VDATA_W-1:0] pix_i,
   input  logic               pix_valid_i,
   output logic               pix_ready_o,
   input  logic [2:0]         modeparams_i,
   output logic               nVDSYNC_o,
   output logic [COLOR_W-1:0] VD_o,
   output logic               underrun_o
);

   vphase_t            ph_q, ph_d;
   vpix_t              cur_q, cur_d;
   logic               rep_q, rep_d;
   logic [2:0]         mode_q, mode_d;

   logic               boundary;
   logic               rep_slot;
   logic               accept;
   logic               blank;
   logic [COLOR_W-1:0] chan;
   logic               nvdsync_d;
   logic [COLOR_W-1:0] vd_d;
   logic               underrun_d;

   // Next-state: phase advance, pixel boundary decision and the output word for the phase being entered.
   always_comb begin
      ph_d        = vphase_t'(ph_q + 2'd1);
      cur_d       = cur_q;
      rep_d       = rep_q;
      mode_d      = mode_q;
      underrun_d  = 1'b0;
      chan        = '0;
      nvdsync_d   = 1'b1;
      vd_d        = '0;

      boundary    = (ph_q == PH_B);
      rep_slot    = mode_q[MODE_LOWRES_REP] & ~rep_q;
      pix_ready_o = nRST & boundary & ~rep_slot;
      accept      = pix_ready_o & pix_valid_i;

      if (boundary) begin
         if (accept) begin
            cur_d  = vpix_t'(pix_i);
            rep_d  = 1'b0;
            mode_d = modeparams_i;
         end else if (rep_slot) begin
            // Second copy of a low-res pixel; mode stays locked to the pair.
            rep_d = 1'b1;
         end else begin
            // Nothing offered: resend the last pixel (sync included).
            mode_d     = modeparams_i;
            underrun_d = nRST;
         end
      end

      // Only the sync phase is entered at a boundary, so the _d view is valid for every phase.
      blank = mode_d[MODE_LOWRES_REP] & mode_d[MODE_BLANK_REP] & rep_d;

      case (ph_d)
         PH_R:    chan = cur_d.r;
         PH_G:    chan = cur_d.g;
         PH_B:    chan = cur_d.b;
         default: chan = '0;
      endcase

      if (ph_d == PH_SYNC) begin
         nvdsync_d = 1'b0;
         vd_d      = {3'b000, cur_d.sync};
      end else begin
         nvdsync_d = 1'b1;
         vd_d      = blank ? '0 : fmt_color(chan, mode_d[MODE_N15BIT]);
      end
   end

   // State and registered bus outputs; reset parks on the B phase so the next edge is a clean boundary.
   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         ph_q       <= PH_B;
         cur_q      <= '{b: '0, g: '0, r: '0, sync: 4'hF};
         rep_q      <= 1'b1;
         mode_q     <= 3'b000;
         nVDSYNC_o  <= 1'b1;
         VD_o       <= '0;
         underrun_o <= 1'b0;
      end else begin
         ph_q       <= ph_d;
         cur_q      <= cur_d;
         rep_q      <= rep_d;
         mode_q     <= mode_d;
         nVDSYNC_o  <= nvdsync_d;
         VD_o       <= vd_d;
         underrun_o <= underrun_d;
      end
   end

endmodule
